// File: rtl/mem_stage.sv
// MEM stage of the RV64 pipeline: issues data-bus loads/stores for the EX/MEM
// instruction, stalls upstream until the bus completes, registers the result for WB.
package mem_stage_pkg;
   typedef struct packed {
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic [2:0] MemSize;
      logic [2:0] wbType;
   } ctl_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] raw_instr;
      ctl_t        ctl;
      logic [4:0]  dst;
      logic [63:0] alu_out;
      logic [63:0] MemWriteData;
   } execute_data_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] raw_instr;
      ctl_t        ctl;
      logic [4:0]  dst;
      logic [63:0] alu_out;
      logic [63:0] MemReadData;
   } memory_data_t;
endpackage

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int BYTE_LANES = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  execute_data_t           ex_data,
   output logic                    mem_stall,
   output logic                    dreq_valid,
   output logic [63:0]             dreq_addr,
   output logic [2:0]              dreq_size,
   output logic [BYTE_LANES-1:0]   dreq_strobe,
   output logic [63:0]             dreq_data,
   input  logic                    dresp_data_ok,
   input  logic [63:0]             dresp_data,
   output memory_data_t            mem_data
);
   localparam int OFF_W = $clog2(BYTE_LANES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state_reg, state_next;
   memory_data_t   mem_data_reg, mem_data_next;
   logic           memop;
   logic           is_store;
   logic           is_load;
   logic [OFF_W-1:0] off;
   logic [5:0]     lane_shift;

   assign memop      = ex_data.valid & (ex_data.ctl.MemRead | ex_data.ctl.MemWrite);
   assign is_store   = ex_data.valid & ex_data.ctl.MemWrite;
   assign is_load    = ex_data.valid & ex_data.ctl.MemRead;
   assign off        = ex_data.alu_out[OFF_W-1:0];
   assign lane_shift = {off, 3'b000};

   // Request fields follow ex_data directly; EX/MEM is frozen while we stall.
   assign dreq_addr = ex_data.alu_out;
   assign dreq_size = ex_data.ctl.MemSize;
   assign dreq_data = ex_data.MemWriteData << lane_shift;

   always_comb begin
      dreq_strobe = '0;
      if (!reset && is_store) begin
         case (ex_data.ctl.MemSize[1:0])
            2'b00:   dreq_strobe = 8'h01 << off;
            2'b01:   dreq_strobe = 8'h03 << off;
            2'b10:   dreq_strobe = 8'h0F << off;
            default: dreq_strobe = 8'hFF;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (memop && !dresp_data_ok) state_next = BUSY;
         BUSY:    if (dresp_data_ok)           state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      dreq_valid = 1'b0;
      mem_stall  = 1'b0;
      if (!reset) begin
         case (state_reg)
            IDLE:    dreq_valid = memop;
            BUSY:    dreq_valid = 1'b1;
            default: dreq_valid = 1'b0;
         endcase
         mem_stall = dreq_valid & ~dresp_data_ok;
      end
   end

   always_comb begin
      mem_data_next             = '0;
      mem_data_next.valid       = ex_data.valid;
      mem_data_next.pc          = ex_data.pc;
      mem_data_next.raw_instr   = ex_data.raw_instr;
      mem_data_next.ctl         = ex_data.ctl;
      mem_data_next.dst         = ex_data.dst;
      mem_data_next.alu_out     = ex_data.alu_out;
      mem_data_next.MemReadData = is_load ? (dresp_data >> lane_shift) : 64'd0;
   end

   // A stalled cycle sends a bubble to WB but keeps the payload fields.
   always_ff @(posedge clk) begin
      if (reset)          mem_data_reg       <= '0;
      else if (mem_stall) mem_data_reg.valid <= 1'b0;
      else                mem_data_reg       <= mem_data_next;
   end

   assign mem_data = mem_data_reg;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage of the 5-stage RV64 core; sits between EX and WB.
- Consumes execute_data_t from the EX/MEM register and issues load/store requests on the data bus.
- Stalls upstream until the bus responds, then registers a memory_data_t for WB.
- Produces raw loaded data only; WB performs truncation and extension per ctl.wbType.

Parameters:
- BYTE_LANES, 8, data bus width in bytes; fixed at 8 for RV64.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_data  in  execute_data_t  instruction from EX; ex_data.valid qualifies it
- mem_stall  out  1  hold EX/MEM and all earlier stages this cycle
- dreq_valid  out  1  data-bus request valid
- dreq_addr  out  64  byte address = ex_data.alu_out
- dreq_size  out  3  000=1B, 001=2B, 010=4B, 011=8B (from ctl.MemSize)
- dreq_strobe  out  8  byte-write enables; 0 for loads
- dreq_data  out  64  write data aligned to byte lanes
- dresp_data_ok  in  1  bus completes the access this cycle
- dresp_data  in  64  read data, lane-aligned
- mem_data  out  memory_data_t  registered output to WB

Behaviour:
- Memop = ex_data.valid & (ctl.MemRead | ctl.MemWrite). ctl.MemRead and ctl.MemWrite are never both 1.
- FSM states:
  - IDLE: if memop, dreq_valid=1. If dresp_data_ok=1 in the same cycle, mem_stall=0 and the result is registered at the edge. Otherwise mem_stall=1 and the FSM goes to BUSY.
  - BUSY: dreq_valid=1, mem_stall = !dresp_data_ok. On dresp_data_ok the FSM returns to IDLE and the result is registered.
- Request fields are combinational from ex_data. They stay stable because EX/MEM is held by mem_stall.
- Address offset is off = alu_out[2:0].
- Strobe, stores only, with bits above 7 dropped:
  - 1B: 8'h01<<off
  - 2B: 8'h03<<off
  - 4B: 8'h0F<<off
  - 8B: 8'hFF
- dreq_data = MemWriteData << (8*off).
- Misaligned accesses are not detected; they are issued as computed above.
- Output register (mem_data) load rules:
  - Non-memop, or ex_data.valid=0: loads every cycle with no stall. Latency is 1 cycle.
  - Memop: loads on the completing cycle.
- Output register field mapping:
  - pc, raw_instr, ctl, dst, alu_out are copied from ex_data.
  - valid = ex_data.valid.
  - MemReadData = dresp_data >> (8*off) for loads, 0 otherwise.
- While mem_stall=1, mem_data.valid=0 (bubble into WB). Other fields are don't-care but hold their previous values.
- dresp_data_ok received with no request outstanding (IDLE, no memop) is ignored.
- Reset:
  - While reset=1: dreq_valid=0 and mem_stall=0 combinationally.
  - Next state is IDLE; mem_data is cleared to all-zero (valid=0).
  - Reset during BUSY abandons the access. A late dresp_data_ok after reset is ignored per the rule above.
- Reset values: mem_data=0, state=IDLE, dreq_valid=0, mem_stall=0, dreq_strobe=0.

Test Plan:
- ALU op: ex_data.valid=1, MemRead=MemWrite=0, alu_out=0x1234 -> next cycle mem_data.valid=1, alu_out=0x1234, MemReadData=0, mem_stall never 1, dreq_valid=0.
- Load 4B, addr 0x8000_0004, bus responds after 3 cycles with dresp_data=0xDEADBEEF_00000000:
  - mem_stall=1 and dreq_valid=1 for 3 cycles.
  - mem_data.valid=0 during the stall.
  - Cycle after data_ok: MemReadData=0x00000000_DEADBEEF.
- Store 1B, addr 0x...03, MemWriteData=0xAB, same-cycle data_ok -> dreq_strobe=8'h08, dreq_data=0x00000000_AB000000, mem_stall=0, mem_data.valid=1 next cycle.
- Store 8B, addr 0x...00, data 0x0123456789ABCDEF -> strobe=8'hFF, dreq_data unchanged, dreq_size=3'b011.
- Back-to-back: load (2-cycle wait) then ALU op -> ALU op reaches mem_data exactly 1 cycle after the load's result; no instruction dropped or duplicated.
- Reset asserted in BUSY, then a stray dresp_data_ok the cycle after reset deasserts -> dreq_valid=0, mem_data.valid=0, FSM stays IDLE, stray response ignored.
